// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;

  // Product sign applied to the full 2*XLEN product before picking the half.
  function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] p,
                                              input logic neg, input logic [2:0] f);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (f == F_MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  // Decode of the operands presented with start.
  logic            in_div, in_sa, in_sb, in_ovf, in_special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign in_div     = funct3[2];
  assign in_sa      = op_a[XLEN-1] & ((funct3 == F_MULH) | (funct3 == F_MULHSU) |
                                      (funct3 == F_DIV)  | (funct3 == F_REM));
  assign in_sb      = op_b[XLEN-1] & ((funct3 == F_MULH) | (funct3 == F_DIV) | (funct3 == F_REM));
  assign mag_a      = in_sa ? -op_a : op_a;
  assign mag_b      = in_sb ? -op_b : op_b;
  assign in_ovf     = ((funct3 == F_DIV) | (funct3 == F_REM)) &
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
  assign in_special = in_div & ((op_b == '0) | in_ovf);
  // funct3[1] separates REM/REMU from DIV/DIVU.
  assign special_res = (op_b == '0) ? (funct3[1] ? op_a : '1)
                                    : (funct3[1] ? '0 : op_a);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  // One iteration of the shared datapath: hi/lo hold product halves or remainder/quotient.
  logic [XLEN:0]     mul_add, rem_sh, div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   hi_step, lo_step, quo_s, rem_s, final_res;

  assign mul_add  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign rem_sh   = {hi_q, lo_q[XLEN-1]};
  assign div_diff = {1'b0, rem_sh[XLEN-1:0]} - {1'b0, b_q};
  // A set top bit in the shifted remainder means it already exceeds any divisor.
  assign div_ok   = rem_sh[XLEN] | ~div_diff[XLEN];

  assign hi_step  = op_q[2] ? (div_ok ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0])
                            : mul_add[XLEN:1];
  assign lo_step  = op_q[2] ? {lo_q[XLEN-2:0], div_ok}
                            : {mul_add[0], lo_q[XLEN-1:1]};

  assign quo_s     = (sa_q ^ sb_q) ? -lo_step : lo_step;
  assign rem_s     = sa_q ? -hi_step : hi_step;
  assign final_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                             : mul_sel({hi_step, lo_step}, sa_q ^ sb_q, op_q);

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = funct3;
          sa_d    = in_sa;
          sb_d    = in_sb;
          hi_d    = '0;
          lo_d    = in_div ? mag_a : mag_b;
          b_d     = in_div ? mag_b : mag_a;
          count_d = CW'(XLEN - 1);
          state_d = S_CALC;
          if (in_special) begin
            result_d = special_res;
            state_d  = S_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!in_div) begin
            result_d = mul_sel(fast_prod, in_sa ^ in_sb, funct3);
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = hi_step;
          lo_d    = lo_step;
          count_d = count_q - CW'(1);
          if (count_q == '0) begin
            result_d = final_res;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE) && !flush;
  assign result = result_q;

endmodule
